// File: rtl/fixed_order_scheduler.sv
// rtl/fixed_order_scheduler.sv - block sequencer for a single ChooseBestFixed chooser
//
// Feeds one block of BLOCK_SIZE samples into the chooser, keeps its enable
// running for LATENCY cycles after the last sample so its pipeline empties,
// captures the winning fixed-predictor order and holds it until the residual
// encoder acknowledges it. The chooser's enable and reset are owned here.
//
// Ports:
//   iClock, iReset      clock, asynchronous active-high reset
//   iStart              begin a block (IDLE only)
//   iSampleValid/iSample, oSampleReady   sample stream in
//   oCbfEnable/oCbfReset/oCbfSample      chooser control and data
//   iCbfBest            chooser result
//   oBest/oBestValid, iBestAck           captured order handshake
//   oBusy, oBlockCount  status
`timescale 1ns/1ps
module fixed_order_scheduler #(
    parameter int BLOCK_SIZE = 4096,
    parameter int LATENCY    = 8
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic               iSampleValid,
    input  logic signed [15:0] iSample,
    output logic               oSampleReady,
    output logic               oCbfEnable,
    output logic               oCbfReset,
    output logic signed [15:0] oCbfSample,
    input  logic [2:0]         iCbfBest,
    output logic [2:0]         oBest,
    output logic               oBestValid,
    input  logic               iBestAck,
    output logic               oBusy,
    output logic [15:0]        oBlockCount
);

    localparam int CW = $clog2(BLOCK_SIZE) + 1;
    localparam int DW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAST_IDX   = CW'(BLOCK_SIZE - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               ready_q, ready_d;
    logic               en_q, en_d;
    logic               cbf_rst_q, cbf_rst_d;
    logic signed [15:0] sample_q, sample_d;
    logic [2:0]         best_q, best_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [15:0]        blocks_q, blocks_d;
    logic               accept;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        drain_d  = drain_q;
        sample_d = sample_q;
        best_d   = best_q;
        blocks_d = blocks_q;
        en_d     = 1'b0;
        accept   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_FEED;
                    count_d = '0;
                end
            end
            S_FEED: begin
                accept = iSampleValid & ready_q;
                if (accept) begin
                    sample_d = iSample;
                    en_d     = 1'b1;
                    count_d  = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        // The first DRAIN cycle still carries the final
                        // sample's enable; LATENCY pure drain enables follow.
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    // Chooser output is valid in the last drain-enable cycle.
                    best_d   = iCbfBest;
                    blocks_d = blocks_q + 16'd1;
                    state_d  = S_HOLD;
                end else begin
                    drain_d = drain_q - 1'b1;
                    en_d    = 1'b1;
                end
            end
            S_HOLD: begin
                if (iBestAck) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Remaining outputs are pure functions of the next state, registered.
        ready_d   = (state_d == S_FEED);
        cbf_rst_d = (state_d == S_IDLE);
        valid_d   = (state_d == S_HOLD);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            drain_q   <= '0;
            ready_q   <= 1'b0;
            en_q      <= 1'b0;
            cbf_rst_q <= 1'b1;
            sample_q  <= '0;
            best_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            blocks_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            drain_q   <= drain_d;
            ready_q   <= ready_d;
            en_q      <= en_d;
            cbf_rst_q <= cbf_rst_d;
            sample_q  <= sample_d;
            best_q    <= best_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            blocks_q  <= blocks_d;
        end
    end

    assign oSampleReady = ready_q;
    assign oCbfEnable   = en_q;
    assign oCbfReset    = cbf_rst_q;
    assign oCbfSample   = sample_q;
    assign oBest        = best_q;
    assign oBestValid   = valid_q;
    assign oBusy        = busy_q;
    assign oBlockCount  = blocks_q;

endmodule

// File: tb/tb_fixed_order_scheduler.sv
// tb/tb_fixed_order_scheduler.sv - self-checking bench for fixed_order_scheduler
`timescale 1ns/1ps
module tb_fixed_order_scheduler;

    localparam int BS  = 4096;
    localparam int LAT = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start, sv, ack;
    logic signed [15:0] sample;
    logic               ready, cbf_en, cbf_rst, valid, busy;
    logic signed [15:0] cbf_sample;
    logic [2:0]         cbf_best, best, target;
    logic [15:0]        blocks;

    always #5 clk = ~clk;

    fixed_order_scheduler #(.BLOCK_SIZE(BS), .LATENCY(LAT)) dut (
        .iClock(clk), .iReset(rst), .iStart(start),
        .iSampleValid(sv), .iSample(sample), .oSampleReady(ready),
        .oCbfEnable(cbf_en), .oCbfReset(cbf_rst), .oCbfSample(cbf_sample),
        .iCbfBest(cbf_best), .oBest(best), .oBestValid(valid),
        .iBestAck(ack), .oBusy(busy), .oBlockCount(blocks)
    );

    int     n_tests = 0;
    int     n_fail  = 0;
    longint edge_n  = 0;
    longint en_seen = 0;
    bit     chk_on  = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Chooser stand-in: its answer is only meaningful once it has seen every
    // sample plus LATENCY-1 pipeline enables; before that it reports 7.
    int en_cnt = 0;
    always @(posedge clk) begin
        if (cbf_rst === 1'b1) en_cnt <= 0;
        else if (cbf_en === 1'b1) en_cnt <= en_cnt + 1;
    end
    assign cbf_best = (en_cnt >= BS + LAT - 1) ? target : 3'd7;

    // Timeline model: tracks the block's events (start, each accepted
    // sample, edge L of the final sample, ack) and derives every output from
    // the timing rules relative to those events.
    bit                 m_active, m_feeding, m_hold, m_en;
    logic signed [15:0] m_samp;
    logic [2:0]         m_best;
    logic [15:0]        m_blocks;
    int                 m_acc;
    longint             m_last;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 0; m_feeding <= 0; m_hold <= 0; m_en <= 0;
            m_samp <= '0; m_best <= '0; m_blocks <= '0; m_acc <= 0; m_last <= 0;
        end else begin
            m_en <= 1'b0;
            if (m_hold) begin
                if (ack) begin
                    m_hold   <= 1'b0;
                    m_active <= 1'b0;
                end
            end else if (m_active && m_feeding) begin
                if (sv) begin
                    m_en   <= 1'b1;
                    m_samp <= sample;
                    m_acc  <= m_acc + 1;
                    if (m_acc == BS - 1) begin
                        m_feeding <= 1'b0;
                        m_last    <= edge_n + 1;
                    end
                end
            end else if (m_active) begin
                if (edge_n + 1 <= m_last + LAT) m_en <= 1'b1;
                if (edge_n + 1 == m_last + LAT + 1) begin
                    m_best   <= cbf_best;
                    m_hold   <= 1'b1;
                    m_blocks <= m_blocks + 16'd1;
                end
            end else if (start) begin
                m_active  <= 1'b1;
                m_feeding <= 1'b1;
                m_acc     <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            check("ready",      32'(ready),      32'(m_feeding));
            check("cbf_enable", 32'(cbf_en),     32'(m_en));
            check("cbf_reset",  32'(cbf_rst),    32'(!m_active));
            check("cbf_sample", 32'(cbf_sample), 32'(m_samp));
            check("best",       32'(best),       32'(m_best));
            check("best_valid", 32'(valid),      32'(m_hold));
            check("busy",       32'(busy),       32'(m_active));
            check("block_count",32'(blocks),     32'(m_blocks));
            check("en_rst_excl",32'(cbf_en & cbf_rst), 32'(0));
            if (cbf_en === 1'b1) en_seen++;
        end
    end

    function automatic logic signed [15:0] gen(input int blk, input int i);
        int v;
        v = i * 2654435 + blk * 7919;
        return 16'(v ^ (v >>> 7));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [2:0] tgt, input int blk, input bit stall,
                             input int hold_cycles, input bit poke_start,
                             output longint t_start, output longint t_valid,
                             output longint t_idle);
        int     i;
        int     guard;
        bit     ph;
        longint en0;
        target = tgt;
        en0    = en_seen;
        start  = 1'b1;
        tick();
        t_start = edge_n;
        start   = 1'b0;
        i  = 0;
        ph = 1'b1;
        while (i < BS) begin
            sv     = stall ? ph : 1'b1;
            sample = gen(blk, i);
            tick();
            if (sv) i++;
            ph = ~ph;
        end
        sv    = 1'b0;
        guard = 0;
        while (valid !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        check("valid_seen", 32'(guard < 100), 32'(1));
        t_valid = edge_n;
        for (int k = 0; k < hold_cycles; k++) begin
            start = (poke_start && k == 50);
            tick();
        end
        start = poke_start;
        ack   = 1'b1;
        tick();
        t_idle = edge_n;
        ack    = 1'b0;
        start  = 1'b0;
        check("idle_busy",  32'(busy),  32'(0));
        check("idle_valid", 32'(valid), 32'(0));
        check("idle_cbfrst",32'(cbf_rst), 32'(1));
        check("best_lit",   32'(best),  32'(tgt));
        check("enable_total", 32'(en_seen - en0), 32'(BS + LAT));
        tick();
        check("start_with_ack_ignored", 32'(busy), 32'(0));
    endtask

    longint ts, tv, ti, ts2, tv2, ti2;
    logic [2:0] seq [3] = '{3'd0, 3'd4, 3'd2};

    initial begin
        start = 0; sv = 0; ack = 0; sample = '0; target = 3'd3;
        #2 rst = 1'b1;
        #20;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        repeat (10) tick();
        check("rst_busy",   32'(busy),    32'(0));
        check("rst_cbfrst", 32'(cbf_rst), 32'(1));
        check("rst_blocks", 32'(blocks),  32'(0));

        // continuous block, chooser answers 3, immediate ack
        run_block(3'd3, 0, 1'b0, 0, 1'b0, ts, tv, ti);
        check("cont_valid_lat", 32'(tv - ts), 32'(BS + LAT + 1));
        check("cont_turnaround", 32'(ti - ts), 32'(BS + LAT + 2));
        check("cont_blocks", 32'(blocks), 32'(1));

        // stalled feed: valid every other cycle
        run_block(3'd3, 1, 1'b1, 0, 1'b0, ts2, tv2, ti2);
        check("stall_valid_lat", 32'(tv2 - ts2), 32'(2 * BS + LAT));
        check("stall_delay", 32'((tv2 - ts2) - (tv - ts)), 32'(BS - 1));
        check("stall_blocks", 32'(blocks), 32'(2));

        // held handshake with a stray start at hold cycle 50 and with ack
        run_block(3'd1, 2, 1'b0, 100, 1'b1, ts, tv, ti);
        check("held_ack_edge", 32'(ti - tv), 32'(101));
        check("held_blocks", 32'(blocks), 32'(3));

        // reset during FEED after 1000 samples
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            sv = 1'b1;
            sample = gen(3, i);
            tick();
        end
        #2 rst = 1'b1;
        sv = 1'b0;
        #1;
        check("arst_ready",  32'(ready),      32'(0));
        check("arst_en",     32'(cbf_en),     32'(0));
        check("arst_cbfrst", 32'(cbf_rst),    32'(1));
        check("arst_sample", 32'(cbf_sample), 32'(0));
        check("arst_best",   32'(best),       32'(0));
        check("arst_valid",  32'(valid),      32'(0));
        check("arst_busy",   32'(busy),       32'(0));
        check("arst_blocks", 32'(blocks),     32'(0));
        tick();
        rst = 1'b0;
        tick();
        run_block(3'd4, 4, 1'b0, 0, 1'b0, ts, tv, ti);
        check("post_rst_blocks", 32'(blocks), 32'(1));

        // back-to-back blocks with orders 0, 4, 2
        for (int b = 0; b < 3; b++) begin
            run_block(seq[b], 5 + b, 1'b0, 0, 1'b0, ts, tv, ti);
            check("b2b_best", 32'(best), 32'(seq[b]));
            check("b2b_blocks", 32'(blocks), 32'(b + 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
